// File: rtl/v_pkg.sv
// ----------------------------------------------------------------------------
// v_pkg -- shared definitions for the vector issue queue.
//   Major opcodes (OPC_*), OP-V funct3 categories (OPI_*/OPM_*), the funct6
//   values this queue decodes, and the functional-unit port indices (FU_*).
//   Also defines the queue entry layout and the issue FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package v_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_VEC   = 7'h57;  // OP-V
  localparam logic [6:0] OPC_LTYPE = 7'h07;  // LOAD-FP (vector loads)
  localparam logic [6:0] OPC_STYPE = 7'h27;  // STORE-FP (vector stores)

  // OP-V funct3 categories
  localparam logic [2:0] OPI_VV = 3'b000;
  localparam logic [2:0] OPM_VV = 3'b010;
  localparam logic [2:0] OPI_VI = 3'b011;
  localparam logic [2:0] OPI_VX = 3'b100;
  localparam logic [2:0] OPM_VX = 3'b110;
  localparam logic [2:0] OPC_CFG = 3'b111;  // vsetvli / vsetivli / vsetvl

  // funct6 encodings (OPI group)
  localparam logic [5:0] F6_VADD      = 6'b000000;
  localparam logic [5:0] F6_VSUB      = 6'b000010;
  localparam logic [5:0] F6_VRSUB     = 6'b000011;
  localparam logic [5:0] F6_VMINU     = 6'b000100;
  localparam logic [5:0] F6_VMIN      = 6'b000101;
  localparam logic [5:0] F6_VMAXU     = 6'b000110;
  localparam logic [5:0] F6_VMAX      = 6'b000111;
  localparam logic [5:0] F6_VAND      = 6'b001001;
  localparam logic [5:0] F6_VOR       = 6'b001010;
  localparam logic [5:0] F6_VXOR      = 6'b001011;
  localparam logic [5:0] F6_SLIDEUP   = 6'b001110;
  localparam logic [5:0] F6_SLIDEDOWN = 6'b001111;
  localparam logic [5:0] F6_VMV       = 6'b010111;  // vmv.v.* when vm=1
  localparam logic [5:0] F6_VSLL      = 6'b100101;
  localparam logic [5:0] F6_VSRL      = 6'b101000;
  localparam logic [5:0] F6_VSRA      = 6'b101001;
  // funct6 encodings (OPM group)
  localparam logic [5:0] F6_REDSUM    = 6'b000000;
  localparam logic [5:0] F6_REDMAX    = 6'b000111;
  localparam logic [5:0] F6_VMUL      = 6'b100101;

  // Functional-unit port indices
  localparam int FU_ALU   = 0;
  localparam int FU_MUL   = 1;
  localparam int FU_RED   = 2;
  localparam int FU_SLDU  = 3;
  localparam int FU_LSU   = 4;
  localparam int NUM_FU_C = 5;

  localparam int XLEN_C = 32;

  typedef logic [NUM_FU_C-1:0] fu_sel_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN_C-1:0] rs1;
    logic [XLEN_C-1:0] rs2;
  } q_entry_t;

  typedef enum logic [0:0] {
    RUN,
    CFG_WAIT
  } iss_state_t;

  // OPI funct6 values executed by the ALU.
  function automatic logic is_alu_f6(input logic [5:0] f6);
    return f6 inside {F6_VADD, F6_VSUB, F6_VRSUB, F6_VMINU, F6_VMIN, F6_VMAXU,
                      F6_VMAX, F6_VAND, F6_VOR, F6_VXOR, F6_VSLL, F6_VSRL, F6_VSRA};
  endfunction

  // Width field values that select vector (not scalar FP) loads/stores.
  function automatic logic is_vec_width(input logic [2:0] w);
    return w inside {3'b000, 3'b101, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/v_issue_decode.sv
// ----------------------------------------------------------------------------
// v_issue_decode -- purely combinational decode of the issue queue head.
// Ports:
//   instr    in   32      head instruction word
//   unit     out  NUM_FU  one-hot target functional unit (0 if none)
//   legal    out  1       instruction is recognised (includes vconfig)
//   is_cfg   out  1       vsetvl* family
//   use_vs1  out  1       reads vs1 (vector-vector forms)
//   use_vs2  out  1       reads vs2 (all OP-V arithmetic)
//   use_vs3  out  1       reads vs3 (store data, instr[11:7])
//   wr_vd    out  1       writes vd
//   vd/vs1/vs2 out 5      register fields of the word
// ----------------------------------------------------------------------------
module v_issue_decode
  import v_pkg::*;
(
  input  logic [31:0] instr,
  output fu_sel_t     unit,
  output logic        legal,
  output logic        is_cfg,
  output logic        use_vs1,
  output logic        use_vs2,
  output logic        use_vs3,
  output logic        wr_vd,
  output logic [4:0]  vd,
  output logic [4:0]  vs1,
  output logic [4:0]  vs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] funct6;
  logic       vm;

  assign opcode = instr[6:0];
  assign vd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign vs1    = instr[19:15];
  assign vs2    = instr[24:20];
  assign vm     = instr[25];
  assign funct6 = instr[31:26];

  always_comb begin
    unit    = '0;
    legal   = 1'b0;
    is_cfg  = 1'b0;
    use_vs1 = 1'b0;
    use_vs2 = 1'b0;
    use_vs3 = 1'b0;
    wr_vd   = 1'b0;
    case (opcode)
      OPC_VEC: begin
        if (funct3 == OPC_CFG) begin
          legal  = 1'b1;
          is_cfg = 1'b1;
        end else if (funct3 inside {OPI_VV, OPI_VX, OPI_VI}) begin
          if (is_alu_f6(funct6))
            unit[FU_ALU] = 1'b1;
          else if ((funct6 inside {F6_SLIDEUP, F6_SLIDEDOWN}) && funct3 != OPI_VV)
            unit[FU_SLDU] = 1'b1;
          else if (funct6 == F6_VMV && vm)
            unit[FU_SLDU] = 1'b1;
        end else if (funct3 inside {OPM_VV, OPM_VX}) begin
          if (funct6 == F6_VMUL)
            unit[FU_MUL] = 1'b1;
          else if (funct3 == OPM_VV && (funct6 inside {F6_REDSUM, F6_REDMAX}))
            unit[FU_RED] = 1'b1;
        end
        if (|unit) begin
          legal   = 1'b1;
          use_vs1 = funct3 inside {OPI_VV, OPM_VV};
          use_vs2 = 1'b1;
          wr_vd   = 1'b1;
        end
      end
      OPC_LTYPE: begin
        if (is_vec_width(funct3)) begin
          unit[FU_LSU] = 1'b1;
          legal        = 1'b1;
          wr_vd        = 1'b1;
        end
      end
      OPC_STYPE: begin
        if (is_vec_width(funct3)) begin
          unit[FU_LSU] = 1'b1;
          legal        = 1'b1;
          use_vs3      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/v_issue_queue.sv
// ----------------------------------------------------------------------------
// v_issue_queue -- in-order vector instruction queue with vreg scoreboard.
//   Buffers instructions from the scalar core, decodes the head, checks
//   RAW/WAW hazards against a 32-bit scoreboard and issues at most one
//   instruction per cycle to ALU/MUL/RED/SLDU/LSU over valid/ready.
//   vsetvl* waits for the scoreboard to drain, then retires as a cfg pulse.
// Optional feature: define V_WB_BYPASS_EN to let same-cycle writebacks
//   release hazards (0-cycle wb->issue); otherwise the registered
//   scoreboard alone is checked (1-cycle wb->issue).
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        core -> queue handshake (in_ready = !full)
//   in_instr/in_rs1/in_rs2   instruction word and scalar operands
//   iss_valid/iss_ready      one-hot issue request / per-unit accept
//   iss_instr/iss_rs1/iss_rs2 head entry (shared bus)
//   wb_valid/wb_vd           per-unit vreg write completion, unit i at [5i+:5]
//   cfg_valid/cfg_zimm       vconfig retire pulse and instr[30:20]
//   illegal                  pulse when the head is undecodable and dropped
//   count                    queue occupancy
//   busy                     queue non-empty or scoreboard non-zero
// ----------------------------------------------------------------------------
module v_issue_queue
  import v_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_FU = NUM_FU_C,
  parameter int XLEN   = XLEN_C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_rs1,
  input  logic [XLEN-1:0]            in_rs2,
  output logic [NUM_FU-1:0]          iss_valid,
  input  logic [NUM_FU-1:0]          iss_ready,
  output logic [31:0]                iss_instr,
  output logic [XLEN-1:0]            iss_rs1,
  output logic [XLEN-1:0]            iss_rs2,
  input  logic [NUM_FU-1:0]          wb_valid,
  input  logic [5*NUM_FU-1:0]        wb_vd,
  output logic                       cfg_valid,
  output logic [10:0]                cfg_zimm,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  q_entry_t             mem [DEPTH];
  q_entry_t             head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [31:0]          sb, sb_eff, sb_next, sb_set, wb_mask;
  iss_state_t           state, state_next;
  logic                 head_valid, push, pop, hazard;

  fu_sel_t              dec_unit;
  logic                 dec_legal, dec_is_cfg, dec_use_vs1, dec_use_vs2, dec_use_vs3, dec_wr_vd;
  logic [4:0]           dec_vd, dec_vs1, dec_vs2;

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign busy       = head_valid || (|sb);

  assign iss_instr = head.instr;
  assign iss_rs1   = head.rs1;
  assign iss_rs2   = head.rs2;
  assign cfg_zimm  = head.instr[30:20];

  v_issue_decode u_decode (
    .instr   (head.instr),
    .unit    (dec_unit),
    .legal   (dec_legal),
    .is_cfg  (dec_is_cfg),
    .use_vs1 (dec_use_vs1),
    .use_vs2 (dec_use_vs2),
    .use_vs3 (dec_use_vs3),
    .wr_vd   (dec_wr_vd),
    .vd      (dec_vd),
    .vs1     (dec_vs1),
    .vs2     (dec_vs2)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (wb_valid[i]) wb_mask[wb_vd[5*i +: 5]] = 1'b1;
  end

`ifdef V_WB_BYPASS_EN
  assign sb_eff = sb & ~wb_mask;
`else
  assign sb_eff = sb;
`endif

  // Store data (vs3) lives in the vd field, so dec_vd serves both checks.
  assign hazard = (dec_use_vs1 && sb_eff[dec_vs1]) ||
                  (dec_use_vs2 && sb_eff[dec_vs2]) ||
                  ((dec_use_vs3 || dec_wr_vd) && sb_eff[dec_vd]);

  always_comb begin
    state_next = state;
    iss_valid  = '0;
    cfg_valid  = 1'b0;
    illegal    = 1'b0;
    pop        = 1'b0;
    sb_set     = '0;
    if (head_valid) begin
      case (state)
        RUN: begin
          if (!dec_legal) begin
            illegal = 1'b1;
            pop     = 1'b1;
          end else if (dec_is_cfg) begin
            state_next = CFG_WAIT;
          end else if (!hazard) begin
            // Request is independent of iss_ready; only the transfer needs it.
            iss_valid = dec_unit;
            if (|(dec_unit & iss_ready)) begin
              pop = 1'b1;
              if (dec_wr_vd) sb_set[dec_vd] = 1'b1;
            end
          end
        end
        CFG_WAIT: begin
          if (sb_eff == '0) begin
            cfg_valid  = 1'b1;
            pop        = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // An issue set and a writeback clear to the same register: set wins.
  assign sb_next = (sb & ~wb_mask) | sb_set;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sb     <= '0;
    end else begin
      state <= state_next;
      sb    <= sb_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: queue storage is deliberately not reset; count and the pointers
  // define which entries are meaningful, so a reset of the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, rs1: in_rs1, rs2: in_rs2};
  end

endmodule

// File: tb/tb_v_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_v_issue_queue -- self-checking bench for v_issue_queue.
//   Directed scenarios (hazard hold, full queue, vconfig drain, illegal drop,
//   reset mid-stall) followed by randomized traffic, all compared each cycle
//   against a queue/scoreboard reference model built from the block's rules.
// ----------------------------------------------------------------------------
module tb_v_issue_queue;

  localparam int DEPTH = 4;
  localparam int NFU   = 5;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_rs1 = '0, in_rs2 = '0;
  logic [NFU-1:0]   iss_valid;
  logic [NFU-1:0]   iss_ready = '0;
  logic [31:0]      iss_instr;
  logic [XLEN-1:0]  iss_rs1, iss_rs2;
  logic [NFU-1:0]   wb_valid = '0;
  logic [5*NFU-1:0] wb_vd = '0;
  logic             cfg_valid;
  logic [10:0]      cfg_zimm;
  logic             illegal;
  logic [2:0]       count;
  logic             busy;

  always #5 clk = ~clk;

  v_issue_queue #(.DEPTH(DEPTH), .NUM_FU(NFU), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .wb_valid(wb_valid), .wb_vd(wb_vd),
    .cfg_valid(cfg_valid), .cfg_zimm(cfg_zimm), .illegal(illegal),
    .count(count), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] rs1; logic [31:0] rs2; } ent_t;
  typedef struct { bit legal; bit cfg; int unit; bit u1; bit u2; bit u3; bit wr; } dec_t;
  typedef struct { int unit; logic [4:0] vd; } pend_t;

  ent_t        mq[$];
  logic [31:0] msb = '0;
  bit          mwait = 1'b0;
  pend_t       pend[$];

  // Classification straight from the instruction-set rules.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [5:0] f6 = w[31:26];
    bit opi = (f3 == 3'b000) || (f3 == 3'b011) || (f3 == 3'b100);
    bit opm = (f3 == 3'b010) || (f3 == 3'b110);
    bit alu = f6 inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                         6'b000110, 6'b000111, 6'b001001, 6'b001010, 6'b001011,
                         6'b100101, 6'b101000, 6'b101001};
    bit vw  = f3 inside {3'b000, 3'b101, 3'b110, 3'b111};
    d = '{legal: 0, cfg: 0, unit: -1, u1: 0, u2: 0, u3: 0, wr: 0};
    if (op == 7'h57) begin
      if (f3 == 3'b111) begin
        d.legal = 1; d.cfg = 1;
      end else begin
        if (opi && alu) d.unit = 0;
        else if (opi && f3 != 3'b000 && (f6 == 6'b001110 || f6 == 6'b001111)) d.unit = 3;
        else if (opi && f6 == 6'b010111 && w[25]) d.unit = 3;
        else if (opm && f6 == 6'b100101) d.unit = 1;
        else if (f3 == 3'b010 && (f6 == 6'b000000 || f6 == 6'b000111)) d.unit = 2;
        if (d.unit >= 0) begin
          d.legal = 1; d.u2 = 1; d.wr = 1;
          d.u1 = (f3 == 3'b000) || (f3 == 3'b010);
        end
      end
    end else if (op == 7'h07 && vw) begin
      d.legal = 1; d.unit = 4; d.wr = 1;
    end else if (op == 7'h27 && vw) begin
      d.legal = 1; d.unit = 4; d.u3 = 1;
    end
    return d;
  endfunction

  // Compare this cycle's DUT outputs to the model, then advance the model
  // to the state after the coming rising edge.
  task automatic cycle();
    logic [31:0] wbm, eff, setm, h;
    logic [4:0]  exp_iss;
    bit          exp_cfg, exp_ill, pop, push, nwait, haz;
    dec_t        d;
    wbm = '0; setm = '0; exp_iss = '0;
    exp_cfg = 0; exp_ill = 0; pop = 0; nwait = mwait;
    for (int i = 0; i < NFU; i++)
      if (wb_valid[i]) wbm[wb_vd[5*i +: 5]] = 1'b1;
    eff = msb;
`ifdef V_WB_BYPASS_EN
    eff = msb & ~wbm;
`endif
    push = in_valid && (mq.size() < DEPTH);
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("count", count, mq.size());
    check("busy", busy, (mq.size() != 0) || (msb != 0));
    if (mq.size() > 0) begin
      h = mq[0].instr;
      d = ref_decode(h);
      haz = (d.u1 && eff[h[19:15]]) || (d.u2 && eff[h[24:20]]) ||
            ((d.u3 || d.wr) && eff[h[11:7]]);
      if (mwait) begin
        if (eff == 0) begin exp_cfg = 1; pop = 1; nwait = 0; end
      end else if (!d.legal) begin
        exp_ill = 1; pop = 1;
      end else if (d.cfg) begin
        nwait = 1;
      end else if (!haz) begin
        exp_iss = 5'(1 << d.unit);
        if (iss_ready[d.unit]) begin
          pop = 1;
          if (d.wr) begin
            setm[h[11:7]] = 1'b1;
            pend.push_back('{unit: d.unit, vd: h[11:7]});
          end
        end
      end
    end
    check("iss_valid", iss_valid, exp_iss);
    check("cfg_valid", cfg_valid, exp_cfg);
    check("illegal", illegal, exp_ill);
    if (exp_iss != 0) begin
      check("iss_instr", iss_instr, mq[0].instr);
      check("iss_rs1", iss_rs1, mq[0].rs1);
      check("iss_rs2", iss_rs2, mq[0].rs2);
    end
    if (exp_cfg) begin
      check("cfg_zimm", cfg_zimm, mq[0].instr[30:20]);
      check("cfg_rs1", iss_rs1, mq[0].rs1);
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{instr: in_instr, rs1: in_rs1, rs2: in_rs2});
    msb   = (msb & ~wbm) | setm;
    mwait = nwait;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [4:0] rdy, input logic [4:0] wbv, input logic [24:0] wbd);
    @(negedge clk);
    in_valid  = iv;
    in_instr  = ins;
    in_rs1    = r1;
    in_rs2    = r1 ^ 32'h5a5a_5a5a;
    iss_ready = rdy;
    wb_valid  = wbv;
    wb_vd     = wbd;
    #1;
    cycle();
  endtask

  task automatic idle(input logic [4:0] rdy);
    drive(1'b0, 32'h0, 32'h0, rdy, 5'b0, 25'b0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_illegal", illegal, 0);
    mq.delete(); pend.delete(); msb = '0; mwait = 1'b0;
    in_valid = 1'b0; iss_ready = '0; wb_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] opv(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
    return {f6, vm, vs2, vs1, f3, vd, 7'h57};
  endfunction
  function automatic logic [31:0] vadd(input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    return opv(6'b000000, 1'b1, vs2, vs1, 3'b000, vd);
  endfunction
  function automatic logic [31:0] vmul(input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    return opv(6'b100101, 1'b1, vs2, vs1, 3'b010, vd);
  endfunction
  function automatic logic [31:0] vle32(input logic [4:0] vd);
    return {3'b000, 1'b0, 2'b00, 1'b1, 5'b00000, 5'd10, 3'b110, vd, 7'h07};
  endfunction
  function automatic logic [31:0] vse32(input logic [4:0] vs3);
    return {3'b000, 1'b0, 2'b00, 1'b1, 5'b00000, 5'd10, 3'b110, vs3, 7'h27};
  endfunction
  function automatic logic [31:0] vsetvli(input logic [10:0] zimm);
    return {1'b0, zimm, 5'd11, 3'b111, 5'd12, 7'h57};
  endfunction
  function automatic logic [24:0] wb1(input int u, input logic [4:0] vd);
    logic [24:0] v = '0;
    v[5*u +: 5] = vd;
    return v;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0:  return vadd(a, b, c);
      1:  return opv(6'b001011, 1'b1, b, c, 3'b100, a);   // vxor.vx
      2:  return opv(6'b100101, 1'b1, b, c, 3'b011, a);   // vsll.vi
      3:  return vmul(a, b, c);
      4:  return opv(6'b100101, 1'b1, b, c, 3'b110, a);   // vmul.vx
      5:  return opv(6'b000000, 1'b1, b, c, 3'b010, a);   // vredsum
      6:  return opv(6'b001110, 1'b1, b, c, 3'b100, a);   // vslideup.vx
      7:  return opv(6'b010111, 1'b1, 5'd0, c, 3'b000, a); // vmv.v.v
      8:  return vle32(a);
      9:  return vse32(a);
      10: return vsetvli(11'($urandom));
      11: return 32'h0000_0033;
      12: return opv(6'b010111, 1'b0, b, c, 3'b000, a);   // vmerge: not handled
      default: return $urandom;
    endcase
  endfunction

  // Random writebacks drawn from what the model knows is outstanding.
  task automatic rnd_step(input bit iv, input logic [31:0] ins, input logic [4:0] rdy);
    logic [4:0]  wbv = '0;
    logic [24:0] wbd = '0;
    for (int u = 0; u < NFU; u++) begin
      int idx = -1;
      for (int k = 0; k < pend.size(); k++)
        if (pend[k].unit == u) begin idx = k; break; end
      if (idx >= 0 && $urandom_range(0, 2) == 0) begin
        wbv[u] = 1'b1;
        wbd[5*u +: 5] = pend[idx].vd;
        pend.delete(idx);
      end
    end
    drive(iv, ins, $urandom, rdy, wbv, wbd);
  endtask

  initial begin
    do_reset();

    // 1: single vadd issues the cycle after push, holds sb[3] until wb
    drive(1, vadd(5'd3, 5'd1, 5'd2), 32'h11, 5'b00001, 5'b0, 25'b0);
    idle(5'b00001);
    idle(5'b00001);
    drive(0, 32'h0, 32'h0, 5'b0, 5'b00001, wb1(0, 5'd3));
    idle(5'b0);

    // 2: vmul v5,v3,v4 waits for vadd v3 writeback
    drive(1, vadd(5'd3, 5'd1, 5'd2), 32'h21, 5'b00011, 5'b0, 25'b0);
    drive(1, vmul(5'd5, 5'd3, 5'd4), 32'h22, 5'b00011, 5'b0, 25'b0);
    repeat (3) idle(5'b00011);
    drive(0, 32'h0, 32'h0, 5'b00011, 5'b00001, wb1(0, 5'd3));
    idle(5'b00011);
    drive(0, 32'h0, 32'h0, 5'b0, 5'b00010, wb1(1, 5'd5));
    idle(5'b0);

    // 3: fill to DEPTH with no unit ready, fifth held, then drain in order
    for (int k = 0; k < 5; k++)
      drive(1, vadd(5'(8 + k), 5'd20, 5'd21), 32'(k), 5'b0, 5'b0, 25'b0);
    drive(1, vadd(5'd12, 5'd20, 5'd21), 32'h4, 5'b00001, 5'b0, 25'b0);
    repeat (5) idle(5'b00001);
    for (int k = 0; k < 5; k++)
      drive(0, 32'h0, 32'h0, 5'b0, 5'b00001, wb1(0, 5'(8 + k)));

    // 4: vsetvli waits for the outstanding load, then vadd follows
    drive(1, vle32(5'd2), 32'h40, 5'b11111, 5'b0, 25'b0);
    drive(1, vsetvli(11'h0d3), 32'hABCD, 5'b11111, 5'b0, 25'b0);
    drive(1, vadd(5'd6, 5'd7, 5'd8), 32'h42, 5'b11111, 5'b0, 25'b0);
    repeat (3) idle(5'b11111);
    drive(0, 32'h0, 32'h0, 5'b11111, 5'b10000, wb1(4, 5'd2));
    repeat (2) idle(5'b11111);
    drive(0, 32'h0, 32'h0, 5'b0, 5'b00001, wb1(0, 5'd6));

    // 5: undecodable head is dropped, the next instruction issues
    drive(1, 32'h0000_0033, 32'h50, 5'b00001, 5'b0, 25'b0);
    drive(1, vadd(5'd9, 5'd1, 5'd2), 32'h51, 5'b00001, 5'b0, 25'b0);
    repeat (2) idle(5'b00001);
    drive(0, 32'h0, 32'h0, 5'b0, 5'b00001, wb1(0, 5'd9));

    // 6: reset while vmul is stalled on sb[3]
    drive(1, vadd(5'd3, 5'd1, 5'd2), 32'h61, 5'b00011, 5'b0, 25'b0);
    drive(1, vmul(5'd5, 5'd3, 5'd4), 32'h62, 5'b00011, 5'b0, 25'b0);
    repeat (2) idle(5'b00011);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 1500; n++)
      rnd_step($urandom_range(0, 3) != 0, rnd_instr(), 5'($urandom));

    // Drain: stop pushing, units always ready, until the model is empty
    for (int n = 0; n < 600 && (mq.size() != 0 || msb != 0); n++)
      rnd_step(1'b0, 32'h0, 5'b11111);
    idle(5'b11111);
    check("final_busy", busy, 0);
    check("final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
